// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - control-signal interface between the sequencer and the Mini SRC datapath
interface control_sequencer_if;
  logic [31:0] IR;
  logic        BranchOut;
  logic        Stop;
  logic        Run;
  logic        PCout, Zlowout, Zhighout, MDRout, LOout, HIout, InPortout, Cout, BAout;
  logic        PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin, OutPortIn, Rin;
  logic        Gra, Grb, Grc, Rout;
  logic        Read, Write, IncPC;
  logic        ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  logic        Clear_dp;

  modport master (
    input  IR, BranchOut, Stop,
    output Run,
    output PCout, Zlowout, Zhighout, MDRout, LOout, HIout, InPortout, Cout, BAout,
    output PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin, OutPortIn, Rin,
    output Gra, Grb, Grc, Rout, Read, Write, IncPC,
    output ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    output Clear_dp
  );

  modport slave (
    output IR, BranchOut, Stop,
    input  Run,
    input  PCout, Zlowout, Zhighout, MDRout, LOout, HIout, InPortout, Cout, BAout,
    input  PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin, OutPortIn, Rin,
    input  Gra, Grb, Grc, Rout, Read, Write, IncPC,
    input  ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT,
    input  Clear_dp
  );
endinterface

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired T0-T7 control unit for the Mini SRC datapath
module control_sequencer #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input logic                 Clock,
  input logic                 Clear,
  control_sequencer_if.master cs
);
  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_PAUSE, S_HALT
  } state_t;

  typedef struct packed {
    logic PCout, Zlowout, Zhighout, MDRout, LOout, HIout, InPortout, Cout, BAout;
    logic PCin, IRin, MARin, MDRin, Yin, Zin, LOin, HIin, CONin, OutPortIn, Rin;
    logic Gra, Grb, Grc, Rout, Read, Write, IncPC;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
  } ctrl_t;

  state_t     state;
  state_t     last_step;
  ctrl_t      c;
  logic       halt_op;
  logic       use_op;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = cs.IR[31:27];
  assign unused_ir = ^cs.IR[26:0];

  always_comb begin
    last_step = S_T3;
    case (op) inside
      5'd1, [5'd3:5'd14]:                last_step = S_T5;
      5'd0:                              last_step = S_T7;
      5'd2, 5'd15, 5'd16, 5'd19:         last_step = S_T6;
      5'd17, 5'd18:                      last_step = S_T4;
      default:                           last_step = S_T3;
    endcase
  end

  assign halt_op = (op == 5'd27) ||
                   (ILLEGAL_HALT && ((op == 5'd21) || (op >= 5'd28)));

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state <= S_RST;
    end else begin
      case (state)
        S_RST, S_T0, S_T1, S_T2: state <= state_t'(state + 4'd1);
        S_PAUSE:                 if (!cs.Stop) state <= S_T0;
        S_HALT:                  state <= S_HALT;
        default: begin
          // Stop is only looked at on the edge that closes an instruction
          if (state == S_T3 && halt_op)  state <= S_HALT;
          else if (state == last_step)   state <= cs.Stop ? S_PAUSE : S_T0;
          else                           state <= state_t'(state + 4'd1);
        end
      endcase
    end
  end

  always_comb begin
    c      = '0;
    use_op = 1'b0;
    case (state)
      S_T0: begin c.PCout = 1'b1; c.MARin = 1'b1; c.IncPC = 1'b1; c.Zin = 1'b1; end
      S_T1: begin c.Zlowout = 1'b1; c.PCin = 1'b1; c.Read = 1'b1; c.MDRin = 1'b1; end
      S_T2: begin c.MDRout = 1'b1; c.IRin = 1'b1; end
      S_T3: case (op) inside
        [5'd3:5'd14]:  begin c.Grb = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
        [5'd0:5'd2]:   begin c.Grb = 1'b1; c.BAout = 1'b1; c.Yin = 1'b1; end
        5'd15, 5'd16:  begin c.Gra = 1'b1; c.Rout = 1'b1; c.Yin = 1'b1; end
        5'd17, 5'd18:  begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; use_op = 1'b1; end
        5'd19:         begin c.Gra = 1'b1; c.Rout = 1'b1; c.CONin = 1'b1; end
        5'd20:         begin c.Gra = 1'b1; c.Rout = 1'b1; c.PCin = 1'b1; end
        5'd22:         begin c.InPortout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        5'd23:         begin c.Gra = 1'b1; c.Rout = 1'b1; c.OutPortIn = 1'b1; end
        5'd24:         begin c.HIout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        5'd25:         begin c.LOout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        default:       ;
      endcase
      S_T4: case (op) inside
        [5'd3:5'd11]:  begin c.Grc = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; use_op = 1'b1; end
        [5'd12:5'd14]: begin c.Cout = 1'b1; c.Zin = 1'b1; use_op = 1'b1; end
        [5'd0:5'd2]:   begin c.Cout = 1'b1; c.ADD = 1'b1; c.Zin = 1'b1; end
        5'd15, 5'd16:  begin c.Grb = 1'b1; c.Rout = 1'b1; c.Zin = 1'b1; use_op = 1'b1; end
        5'd17, 5'd18:  begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        5'd19:         begin c.PCout = 1'b1; c.Yin = 1'b1; end
        default:       ;
      endcase
      S_T5: case (op) inside
        5'd1, [5'd3:5'd14]: begin c.Zlowout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
        5'd0, 5'd2:    begin c.Zlowout = 1'b1; c.MARin = 1'b1; end
        5'd15, 5'd16:  begin c.Zlowout = 1'b1; c.LOin = 1'b1; end
        5'd19:         begin c.Cout = 1'b1; c.ADD = 1'b1; c.Zin = 1'b1; end
        default:       ;
      endcase
      S_T6: case (op)
        5'd0:          begin c.Read = 1'b1; c.MDRin = 1'b1; end
        5'd2:          begin c.Gra = 1'b1; c.Rout = 1'b1; c.Write = 1'b1; end
        5'd15, 5'd16:  begin c.Zhighout = 1'b1; c.HIin = 1'b1; end
        // the only Mealy term: branch target loads PC when the CON flop says so
        5'd19:         begin c.Zlowout = cs.BranchOut; c.PCin = cs.BranchOut; end
        default:       ;
      endcase
      S_T7: if (op == 5'd0) begin c.MDRout = 1'b1; c.Gra = 1'b1; c.Rin = 1'b1; end
      default: ;
    endcase
    if (use_op) begin
      case (op)
        5'd3, 5'd12: c.ADD  = 1'b1;
        5'd4:        c.SUB  = 1'b1;
        5'd5, 5'd13: c.AND  = 1'b1;
        5'd6, 5'd14: c.OR   = 1'b1;
        5'd7:        c.ROR  = 1'b1;
        5'd8:        c.ROL  = 1'b1;
        5'd9:        c.SHR  = 1'b1;
        5'd10:       c.SHRA = 1'b1;
        5'd11:       c.SHL  = 1'b1;
        5'd15:       c.DIV  = 1'b1;
        5'd16:       c.MUL  = 1'b1;
        5'd17:       c.NEG  = 1'b1;
        5'd18:       c.NOT  = 1'b1;
        default:     ;
      endcase
    end
  end

  assign cs.Run      = (state >= S_T0) && (state <= S_T7);
  assign cs.Clear_dp = ~Clear;

  assign cs.PCout = c.PCout;   assign cs.Zlowout = c.Zlowout;     assign cs.Zhighout = c.Zhighout;
  assign cs.MDRout = c.MDRout; assign cs.LOout = c.LOout;         assign cs.HIout = c.HIout;
  assign cs.InPortout = c.InPortout; assign cs.Cout = c.Cout;     assign cs.BAout = c.BAout;
  assign cs.PCin = c.PCin;     assign cs.IRin = c.IRin;           assign cs.MARin = c.MARin;
  assign cs.MDRin = c.MDRin;   assign cs.Yin = c.Yin;             assign cs.Zin = c.Zin;
  assign cs.LOin = c.LOin;     assign cs.HIin = c.HIin;           assign cs.CONin = c.CONin;
  assign cs.OutPortIn = c.OutPortIn; assign cs.Rin = c.Rin;
  assign cs.Gra = c.Gra;       assign cs.Grb = c.Grb;             assign cs.Grc = c.Grc;
  assign cs.Rout = c.Rout;     assign cs.Read = c.Read;           assign cs.Write = c.Write;
  assign cs.IncPC = c.IncPC;
  assign cs.ADD = c.ADD;       assign cs.SUB = c.SUB;             assign cs.MUL = c.MUL;
  assign cs.DIV = c.DIV;       assign cs.AND = c.AND;             assign cs.OR = c.OR;
  assign cs.SHR = c.SHR;       assign cs.SHRA = c.SHRA;           assign cs.SHL = c.SHL;
  assign cs.ROR = c.ROR;       assign cs.ROL = c.ROL;             assign cs.NEG = c.NEG;
  assign cs.NOT = c.NOT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized scoreboard bench for control_sequencer
module tb_control_sequencer;
  localparam bit ILLEGAL_HALT = 1'b0;

  logic Clock = 1'b0;
  logic Clear = 1'b0;

  control_sequencer_if cs();

  control_sequencer #(.ILLEGAL_HALT(ILLEGAL_HALT)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .cs   (cs)
  );

  always #5 Clock = ~Clock;

  localparam logic [39:0] M_PCOUT = 40'd1 << 0,  M_ZLOWOUT = 40'd1 << 1,  M_ZHIGHOUT = 40'd1 << 2;
  localparam logic [39:0] M_MDROUT = 40'd1 << 3, M_LOOUT = 40'd1 << 4,    M_HIOUT = 40'd1 << 5;
  localparam logic [39:0] M_INPORTOUT = 40'd1 << 6, M_COUT = 40'd1 << 7,  M_BAOUT = 40'd1 << 8;
  localparam logic [39:0] M_PCIN = 40'd1 << 9,   M_IRIN = 40'd1 << 10,    M_MARIN = 40'd1 << 11;
  localparam logic [39:0] M_MDRIN = 40'd1 << 12, M_YIN = 40'd1 << 13,     M_ZIN = 40'd1 << 14;
  localparam logic [39:0] M_LOIN = 40'd1 << 15,  M_HIIN = 40'd1 << 16,    M_CONIN = 40'd1 << 17;
  localparam logic [39:0] M_OUTPORTIN = 40'd1 << 18, M_RIN = 40'd1 << 19;
  localparam logic [39:0] M_GRA = 40'd1 << 20,   M_GRB = 40'd1 << 21,     M_GRC = 40'd1 << 22;
  localparam logic [39:0] M_ROUT = 40'd1 << 23,  M_READ = 40'd1 << 24,    M_WRITE = 40'd1 << 25;
  localparam logic [39:0] M_INCPC = 40'd1 << 26, M_ADD = 40'd1 << 27,     M_SUB = 40'd1 << 28;
  localparam logic [39:0] M_MUL = 40'd1 << 29,   M_DIV = 40'd1 << 30,     M_AND = 40'd1 << 31;
  localparam logic [39:0] M_OR = 40'd1 << 32,    M_SHR = 40'd1 << 33,     M_SHRA = 40'd1 << 34;
  localparam logic [39:0] M_SHL = 40'd1 << 35,   M_ROR = 40'd1 << 36,     M_ROL = 40'd1 << 37;
  localparam logic [39:0] M_NEG = 40'd1 << 38,   M_NOT = 40'd1 << 39;

  logic [39:0] act;
  assign act = {cs.NOT, cs.NEG, cs.ROL, cs.ROR, cs.SHL, cs.SHRA, cs.SHR, cs.OR, cs.AND, cs.DIV,
                cs.MUL, cs.SUB, cs.ADD, cs.IncPC, cs.Write, cs.Read, cs.Rout, cs.Grc, cs.Grb,
                cs.Gra, cs.Rin, cs.OutPortIn, cs.CONin, cs.HIin, cs.LOin, cs.Zin, cs.Yin,
                cs.MDRin, cs.MARin, cs.IRin, cs.PCin, cs.BAout, cs.Cout, cs.InPortout, cs.HIout,
                cs.LOout, cs.MDRout, cs.Zhighout, cs.Zlowout, cs.PCout};

  typedef struct {
    logic [39:0] mask;
    bit          run;
    bit          cdp;
    logic [4:0]  op;
    int          step;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  logic [39:0] plan[$];
  int          checks = 0;
  int          passes = 0;

  always @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.mask || cs.Run !== e.run || cs.Clear_dp !== e.cdp)
        $display("FAIL strobes op=%0d step=%0d: got strobes=%h Run=%b Clear_dp=%b, want strobes=%h Run=%b Clear_dp=%b",
                 e.op, e.step, act, cs.Run, cs.Clear_dp, e.mask, e.run, e.cdp);
      else
        passes++;
    end
  end

  function automatic logic [39:0] alu_of(input logic [4:0] op);
    case (op)
      5'd3, 5'd12: return M_ADD;
      5'd4:        return M_SUB;
      5'd5, 5'd13: return M_AND;
      5'd6, 5'd14: return M_OR;
      5'd7:        return M_ROR;
      5'd8:        return M_ROL;
      5'd9:        return M_SHR;
      5'd10:       return M_SHRA;
      5'd11:       return M_SHL;
      5'd15:       return M_DIV;
      5'd16:       return M_MUL;
      5'd17:       return M_NEG;
      5'd18:       return M_NOT;
      default:     return 40'd0;
    endcase
  endfunction

  // Reference: the full per-step strobe list of one instruction, fetch included
  task automatic plan_instr(input logic [4:0] op, input bit bo, output bit halts);
    logic [39:0] a;
    a = alu_of(op);
    halts = 1'b0;
    plan.delete();
    plan.push_back(M_PCOUT | M_MARIN | M_INCPC | M_ZIN);
    plan.push_back(M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN);
    plan.push_back(M_MDROUT | M_IRIN);
    if (op >= 5'd3 && op <= 5'd11) begin
      plan.push_back(M_GRB | M_ROUT | M_YIN);
      plan.push_back(M_GRC | M_ROUT | a | M_ZIN);
      plan.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op >= 5'd12 && op <= 5'd14) begin
      plan.push_back(M_GRB | M_ROUT | M_YIN);
      plan.push_back(M_COUT | a | M_ZIN);
      plan.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op <= 5'd2) begin
      plan.push_back(M_GRB | M_BAOUT | M_YIN);
      plan.push_back(M_COUT | M_ADD | M_ZIN);
      if (op == 5'd1) plan.push_back(M_ZLOWOUT | M_GRA | M_RIN);
      else            plan.push_back(M_ZLOWOUT | M_MARIN);
      if (op == 5'd0) begin
        plan.push_back(M_READ | M_MDRIN);
        plan.push_back(M_MDROUT | M_GRA | M_RIN);
      end
      if (op == 5'd2) plan.push_back(M_GRA | M_ROUT | M_WRITE);
    end else if (op == 5'd15 || op == 5'd16) begin
      plan.push_back(M_GRA | M_ROUT | M_YIN);
      plan.push_back(M_GRB | M_ROUT | a | M_ZIN);
      plan.push_back(M_ZLOWOUT | M_LOIN);
      plan.push_back(M_ZHIGHOUT | M_HIIN);
    end else if (op == 5'd17 || op == 5'd18) begin
      plan.push_back(M_GRB | M_ROUT | a | M_ZIN);
      plan.push_back(M_ZLOWOUT | M_GRA | M_RIN);
    end else if (op == 5'd19) begin
      plan.push_back(M_GRA | M_ROUT | M_CONIN);
      plan.push_back(M_PCOUT | M_YIN);
      plan.push_back(M_COUT | M_ADD | M_ZIN);
      plan.push_back(bo ? (M_ZLOWOUT | M_PCIN) : 40'd0);
    end else begin
      case (op)
        5'd20:   plan.push_back(M_GRA | M_ROUT | M_PCIN);
        5'd22:   plan.push_back(M_INPORTOUT | M_GRA | M_RIN);
        5'd23:   plan.push_back(M_GRA | M_ROUT | M_OUTPORTIN);
        5'd24:   plan.push_back(M_HIOUT | M_GRA | M_RIN);
        5'd25:   plan.push_back(M_LOOUT | M_GRA | M_RIN);
        5'd26:   plan.push_back(40'd0);
        5'd27:   begin plan.push_back(40'd0); halts = 1'b1; end
        default: begin plan.push_back(40'd0); halts = ILLEGAL_HALT; end
      endcase
    end
  endtask

  task automatic cycle(input logic [39:0] m, input bit run, input bit cdp, input bit stop,
                       input bit bo, input logic [31:0] ir, input logic clr,
                       input logic [4:0] op, input int step);
    exp_t x;
    @(posedge Clock);
    #1;
    Clear        = clr;
    cs.IR        = ir;
    cs.Stop      = stop;
    cs.BranchOut = bo;
    x.mask = m; x.run = run; x.cdp = cdp; x.op = op; x.step = step;
    exp_q.push_back(x);
  endtask

  task automatic reset_seq(input int n);
    for (int k = 0; k < n; k++)
      cycle(40'd0, 1'b0, 1'b1, 1'($urandom), 1'($urandom), $urandom, 1'b0, 5'd0, 200 + k);
    cycle(40'd0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), $urandom, 1'b1, 5'd0, 250);
  endtask

  task automatic run_instr(input logic [4:0] op, input bit bo, input bit stop_end,
                           input int pause_len, input int abort_at);
    bit          halts;
    logic [31:0] ir;
    logic [31:0] fetch_ir;
    plan_instr(op, bo, halts);
    ir = {op, 27'($urandom)};
    for (int i = 0; i < plan.size(); i++) begin
      bit last;
      bit st;
      if (i == abort_at) begin
        reset_seq(3);
        return;
      end
      last = (i == plan.size() - 1);
      st   = last ? stop_end : 1'($urandom);
      fetch_ir = $urandom;
      cycle(plan[i], 1'b1, 1'b0, st, (i == 6) ? bo : 1'($urandom),
            (i < 3) ? fetch_ir : ir, 1'b1, op, i);
    end
    if (halts) begin
      for (int k = 0; k < 20; k++)
        cycle(40'd0, 1'b0, 1'b0, 1'($urandom), 1'($urandom), ir, 1'b1, op, 100 + k);
      reset_seq(2);
    end else if (stop_end) begin
      for (int k = 0; k < pause_len; k++)
        cycle(40'd0, 1'b0, 1'b0, (k < pause_len - 1), 1'($urandom), ir, 1'b1, op, 50 + k);
    end
  endtask

  initial begin
    logic [4:0] rop;
    cs.IR        = 32'd0;
    cs.Stop      = 1'b0;
    cs.BranchOut = 1'b0;

    reset_seq(2);
    run_instr(5'd3, 1'b0, 1'b0, 0, -1);          // add from the directed IR pattern
    run_instr(5'd0, 1'b0, 1'b0, 0, -1);          // ld, 8 cycles
    run_instr(5'd19, 1'b0, 1'b0, 0, -1);         // br not taken
    run_instr(5'd19, 1'b1, 1'b0, 0, -1);         // br taken
    run_instr(5'd3, 1'b0, 1'b1, 3, -1);          // add then pause
    run_instr(5'd29, 1'b0, 1'b0, 0, -1);         // undefined opcode
    run_instr(5'd2, 1'b0, 1'b0, 0, -1);          // st
    run_instr(5'd3, 1'b0, 1'b0, 0, 4);           // Clear mid-T4
    run_instr(5'd27, 1'b0, 1'b0, 0, -1);         // halt, then Clear

    for (int n = 0; n < 300; n++) begin
      rop = 5'($urandom);
      if (rop == 5'd27) rop = 5'd26;
      run_instr(rop, 1'($urandom), ($urandom_range(0, 3) == 0), $urandom_range(1, 3),
                ($urandom_range(0, 40) == 0) ? 4 : -1);
    end
    run_instr(5'd27, 1'b0, 1'b0, 0, -1);

    @(negedge Clock);
    @(negedge Clock);
    checks++;
    if (exp_q.size() != 0)
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    else
      passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
